id_ibuf: RTL and testbench
==========================

Name: id_ibuf

Overview:
- Parametrised decode-side instruction buffer between the IF and ID stages.
- Replaces the single {pc, inst} pipeline register and delay-slot flag in front of decode with a DEPTH-entry first-word-fall-through FIFO.
- Adds branch flush and an optional post-flush beat drop.
- Decode reads the head entry combinationally and pops it when it issues to EX.

Parameters:
- BUS_W, 64, width of one fetch beat ({pc[31:0], inst[31:0]} by default).
- DEPTH, 4, number of entries; power of two, >= 2.
- DROP_AFTER_FLUSH, 1, 1 = discard the first beat accepted after a flush (wrong-path fetch); 0 = no drop.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- fs_to_ds_valid, input, 1, fetch beat valid.
- fs_ds_bus, input, BUS_W, fetch beat payload.
- ds_allow_in, output, 1, buffer can accept a beat this cycle.
- flush, input, 1, branch taken in ID; discard all buffered and incoming beats.
- ds_out_valid, output, 1, head entry valid.
- ds_out_bus, output, BUS_W, head entry payload (FWFT).
- ds_out_ready, input, 1, decode consumes head (ds_ready_go && es_allow_in).
- count, output, $clog2(DEPTH)+1, number of valid entries.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.

Behaviour:
Reset:
- Asynchronous on reset high: rd_ptr = 0, wr_ptr = 0, count = 0, drop_pending = 0.
- Outputs during reset: ds_out_valid = 0, empty = 1, full = 0, ds_allow_in = 1.
- Storage RAM is not reset. ds_out_bus is don't-care while ds_out_valid = 0.

Handshakes:
- Handshakes are evaluated only when flush = 0.
- ds_allow_in = !full || ds_out_ready. A same-cycle pop frees a slot, so a full buffer still accepts a beat when decode pops.
- push = fs_to_ds_valid && ds_allow_in && !flush && !(DROP_AFTER_FLUSH && drop_pending).
- drop = fs_to_ds_valid && ds_allow_in && !flush && DROP_AFTER_FLUSH && drop_pending. A dropped beat is handshaken (fetch sees acceptance) but not stored; drop_pending clears on it.
- pop = ds_out_valid && ds_out_ready && !flush.

Outputs:
- ds_out_valid = !empty. ds_out_bus = mem[rd_ptr].
- Zero bypass: a beat pushed in cycle N is visible at the head no earlier than cycle N+1.

Pointers and count:
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- count tracks push/pop: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop on a full buffer keeps count = DEPTH. On an empty buffer pop cannot occur; the beat is written and shown next cycle.

Flush (highest priority):
- On a cycle with flush = 1: rd_ptr <= 0, wr_ptr <= 0, count <= 0, and the incoming beat is ignored.
- drop_pending <= DROP_AFTER_FLUSH. A flush while drop_pending is already set keeps it set.
- ds_allow_in stays as defined during flush, so fetch sees the handshake and advances.
- From the next cycle, ds_out_valid = 0 until a new push.

Reset mid-operation:
- Asynchronously returns all state to reset values; no beat is retained.

Invariants (assertions):
- count <= DEPTH.
- No push when full && !ds_out_ready.
- wr_ptr - rd_ptr == count mod DEPTH.

Test Plan:
- Fill/drain: DEPTH=4, push PCs 0x1c000000..0x1c00000c with ds_out_ready=0 -> full=1, count=4, ds_allow_in=0. Then ds_out_ready=1 with no input -> heads come out in order over 4 cycles, then empty=1.
- Full pass-through: full buffer, ds_out_ready=1 and fs_to_ds_valid=1 for 10 cycles with incrementing PCs -> count stays 4, output order is strictly increasing PC, no beat lost (pointers wrap twice).
- Flush with drop: 3 entries buffered, flush=1 with a beat presented -> next cycle count=0, ds_out_valid=0. Next beat (PC 0x1c000040) is accepted but discarded. Following beat (PC 0x1c000044) appears at head one cycle after its push.
- Flush with DROP_AFTER_FLUSH=0: same stimulus -> the PC 0x1c000040 beat is the head one cycle after push.
- Flush-over-pop: flush=1 with ds_out_ready=1 and a valid head -> no pop counted, count=0 next cycle.
- Async reset: assert reset mid-cycle with count=2 and drop_pending=1 -> outputs go to reset values before the next clock edge. After release, the first beat is stored (no drop).

Source files
------------

// File: rtl/id_ibuf.sv
// id_ibuf: first-word-fall-through instruction buffer between fetch and decode,
// with branch flush and an optional drop of the first wrong-path beat after a flush.
module id_ibuf #(
    parameter int BUS_W            = 64,
    parameter int DEPTH            = 4,
    parameter bit DROP_AFTER_FLUSH = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_to_ds_valid,
    input  logic [BUS_W-1:0]       fs_ds_bus,
    output logic                   ds_allow_in,
    input  logic                   flush,
    output logic                   ds_out_valid,
    output logic [BUS_W-1:0]       ds_out_bus,
    input  logic                   ds_out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BUS_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             drop_pending_q, drop_pending_d;
    logic             accept, push, pop;

    always_comb begin
        full           = count_q == CW'(DEPTH);
        empty          = count_q == '0;
        count          = count_q;
        ds_allow_in    = !full || ds_out_ready;
        ds_out_valid   = !empty;
        ds_out_bus     = mem[rd_ptr_q];
        accept         = fs_to_ds_valid && ds_allow_in && !flush;
        push           = accept && !(DROP_AFTER_FLUSH && drop_pending_q);
        pop            = ds_out_valid && ds_out_ready && !flush;
        rd_ptr_d       = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d       = flush ? '0 : wr_ptr_q + AW'(push);
        count_d        = flush ? '0 : count_q + CW'(push) - CW'(pop);
        // Any accepted beat consumes the pending drop, whether or not it was stored.
        drop_pending_d = flush ? DROP_AFTER_FLUSH : drop_pending_q && !accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            drop_pending_q <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            drop_pending_q <= drop_pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= fs_ds_bus;
    end

    assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (reset) !(push && full && !ds_out_ready));
    assert property (@(posedge clk) disable iff (reset) wr_ptr_q - rd_ptr_q == count_q[AW-1:0]);
endmodule

// File: tb/tb_id_ibuf.sv
// tb_id_ibuf: directed scenarios plus randomized traffic checked against a queue model,
// run on one instance with post-flush drop and one without.
module tb_id_ibuf;
    localparam int BUS_W = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset, fs_to_ds_valid, flush, ds_out_ready;
    logic [BUS_W-1:0] fs_ds_bus;
    logic             a_allow, a_valid, a_full, a_empty, b_allow, b_valid, b_full, b_empty;
    logic [BUS_W-1:0] a_bus, b_bus;
    logic [CW-1:0]    a_count, b_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [BUS_W-1:0] qa[$];
    logic [BUS_W-1:0] qb[$];
    bit pa = 1'b0;

    always #5 clk = ~clk;

    id_ibuf #(.BUS_W(BUS_W), .DEPTH(DEPTH), .DROP_AFTER_FLUSH(1'b1)) dut_a (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_ds_bus(fs_ds_bus),
        .ds_allow_in(a_allow), .flush(flush), .ds_out_valid(a_valid), .ds_out_bus(a_bus),
        .ds_out_ready(ds_out_ready), .count(a_count), .full(a_full), .empty(a_empty));

    id_ibuf #(.BUS_W(BUS_W), .DEPTH(DEPTH), .DROP_AFTER_FLUSH(1'b0)) dut_b (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_ds_bus(fs_ds_bus),
        .ds_allow_in(b_allow), .flush(flush), .ds_out_valid(b_valid), .ds_out_bus(b_bus),
        .ds_out_ready(ds_out_ready), .count(b_count), .full(b_full), .empty(b_empty));

    // Reference model: a bounded FIFO per instance; instance a also drops one beat after flush.
    always @(posedge clk or posedge reset) begin
        bit acc_a, acc_b;
        if (reset) begin
            qa.delete(); qb.delete(); pa = 1'b0;
        end else if (flush) begin
            qa.delete(); qb.delete(); pa = 1'b1;
        end else begin
            acc_a = fs_to_ds_valid && (qa.size() < DEPTH || ds_out_ready);
            acc_b = fs_to_ds_valid && (qb.size() < DEPTH || ds_out_ready);
            if (qa.size() > 0 && ds_out_ready) void'(qa.pop_front());
            if (qb.size() > 0 && ds_out_ready) void'(qb.pop_front());
            if (acc_a && pa) pa = 1'b0;
            else if (acc_a) qa.push_back(fs_ds_bus);
            if (acc_b) qb.push_back(fs_ds_bus);
        end
    end

    function automatic logic [BUS_W-1:0] beat(input logic [31:0] pc);
        return {pc, 32'($urandom())};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        fs_to_ds_valid = v;
        fs_ds_bus      = beat(pc);
        ds_out_ready   = rdy;
        flush          = fl;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", a_empty); end
        n_cmp++; if (a_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", a_full); end
        n_cmp++; if (a_allow !== 1'b1) begin n_err++; $display("FAIL reset_allow: got %b want 1", a_allow); end
        n_cmp++; if (a_count !== 0) begin n_err++; $display("FAIL reset_count: got %0d want 0", a_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1c000000 + 32'(4 * i), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", a_full); end
        n_cmp++; if (a_count !== 4) begin n_err++; $display("FAIL fill_count: got %0d want 4", a_count); end
        n_cmp++; if (a_allow !== 1'b0) begin n_err++; $display("FAIL fill_allow: got %b want 0", a_allow); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            n_cmp++;
            if (a_valid !== 1'b1 || a_bus[63:32] !== 32'h1c000000 + 32'(4 * i)) begin
                n_err++; $display("FAIL drain_head%0d: got v=%b pc=%h want v=1 pc=%h", i, a_valid, a_bus[63:32], 32'h1c000000 + 32'(4 * i));
            end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", a_empty); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] base = 32'h1c000100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, base + 32'(4 * i), 1'b0, 1'b0);
            @(negedge clk);
        end
        for (int k = 0; k < 14; k++) begin
            drive(k < 10, base + 32'(4 * (k + 4)), 1'b1, 1'b0);
            #1;
            n_cmp++;
            if (a_count !== CW'(k < 10 ? 4 : 14 - k) || a_bus[63:32] !== base + 32'(4 * k)) begin
                n_err++; $display("FAIL pass_%0d: got cnt=%0d pc=%h want cnt=%0d pc=%h", k, a_count, a_bus[63:32], k < 10 ? 4 : 14 - k, base + 32'(4 * k));
            end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_drop;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1c000030 + 32'(4 * i), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 32'h1c00003c, 1'b0, 1'b1);
        #1;
        n_cmp++; if (a_allow !== 1'b1) begin n_err++; $display("FAIL flush_allow: got %b want 1", a_allow); end
        @(negedge clk);
        drive(1'b1, 32'h1c000040, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_count !== 0 || a_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear: got cnt=%0d v=%b want 0 0", a_count, a_valid); end
        n_cmp++; if (b_count !== 0) begin n_err++; $display("FAIL flush_clear_b: got %0d want 0", b_count); end
        @(negedge clk);
        drive(1'b1, 32'h1c000044, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL drop_beat: got v=%b want 0", a_valid); end
        n_cmp++; if (b_valid !== 1'b1 || b_bus[63:32] !== 32'h1c000040) begin n_err++; $display("FAIL nodrop_head: got v=%b pc=%h want 1 1c000040", b_valid, b_bus[63:32]); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_valid !== 1'b1 || a_bus[63:32] !== 32'h1c000044 || a_count !== 1) begin
            n_err++; $display("FAIL after_drop_head: got v=%b pc=%h cnt=%0d want 1 1c000044 1", a_valid, a_bus[63:32], a_count);
        end
        n_cmp++; if (b_count !== 2) begin n_err++; $display("FAIL nodrop_count: got %0d want 2", b_count); end
    endtask

    task automatic test_flush_pop;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_count !== 0 || a_empty !== 1'b1) begin n_err++; $display("FAIL flush_pop_a: got cnt=%0d e=%b want 0 1", a_count, a_empty); end
        n_cmp++; if (b_count !== 0) begin n_err++; $display("FAIL flush_pop_b: got %0d want 0", b_count); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1c000050 + 32'(4 * i), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_count !== 2 || a_bus[63:32] !== 32'h1c000054) begin n_err++; $display("FAIL pre_reset: got cnt=%0d pc=%h want 2 1c000054", a_count, a_bus[63:32]); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (a_count !== 0 || a_valid !== 1'b0 || a_empty !== 1'b1 || a_allow !== 1'b1 || a_full !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got cnt=%0d v=%b e=%b a=%b f=%b want 0 0 1 1 0", a_count, a_valid, a_empty, a_allow, a_full);
        end
        n_cmp++; if (b_count !== 0) begin n_err++; $display("FAIL async_reset_b: got %0d want 0", b_count); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h1c000060, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (a_valid !== 1'b1 || a_bus[63:32] !== 32'h1c000060) begin n_err++; $display("FAIL reset_clears_drop: got v=%b pc=%h want 1 1c000060", a_valid, a_bus[63:32]); end
    endtask

    task automatic test_random;
        for (int k = 0; k < 400; k++) begin
            fs_to_ds_valid = $urandom_range(0, 9) < 7;
            ds_out_ready   = $urandom_range(0, 1) == 1;
            flush          = $urandom_range(0, 19) == 0;
            fs_ds_bus      = {32'h1c000000 + 32'(4 * k), 32'($urandom())};
            #1;
            n_cmp++;
            if (a_count !== CW'(qa.size()) || a_valid !== (qa.size() != 0) || a_full !== (qa.size() == DEPTH)
                || a_allow !== (qa.size() < DEPTH || ds_out_ready) || (qa.size() != 0 && a_bus !== qa[0])) begin
                n_err++; $display("FAIL rand_a_%0d: got cnt=%0d v=%b al=%b bus=%h want cnt=%0d", k, a_count, a_valid, a_allow, a_bus, qa.size());
            end
            n_cmp++;
            if (b_count !== CW'(qb.size()) || b_valid !== (qb.size() != 0) || b_empty !== (qb.size() == 0)
                || b_allow !== (qb.size() < DEPTH || ds_out_ready) || (qb.size() != 0 && b_bus !== qb[0])) begin
                n_err++; $display("FAIL rand_b_%0d: got cnt=%0d v=%b al=%b bus=%h want cnt=%0d", k, b_count, b_valid, b_allow, b_bus, qb.size());
            end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush_drop();
        test_flush_pop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
